decode_buffer: RTL
==================

// Module: decode_buffer
// PURPOSE
//  Registered, buffered RV32I decode stage between the instruction queue and the dispatcher.
//  Decodes one instruction per cycle into a DEPTH-entry FIFO with a valid/ready handshake on both sides.
//  Raises registered JAL redirects to IF and branch hints to the branch predictor.
//  Flags illegal encodings and empties itself on a pipeline flush.
// PARAMETERS
//  ADDR_WIDTH    32  PC / address width
//  INST_WIDTH    32  instruction and immediate width
//  REG_WIDTH      5  register index width
//  OPCODE_WIDTH   6  internal instruction-type width (`InstTypeWidth)
//  DEPTH          4  FIFO entries; power of two, >= 2
// PORTS
//  clk_in                          in   1             clock
//  rst_in                          in   1             reset; asynchronous, active-high
//  rdy_in                          in   1             global enable; low = hold all state
//  flush_in                        in   1             mispredict flush
//  instqueue_decoder_en_in         in   1             upstream valid
//  instqueue_decoder_inst_in       in   INST_WIDTH    instruction word
//  instqueue_decoder_pc_in         in   ADDR_WIDTH    instruction PC
//  decoder_instqueue_rdy_out       out  1             upstream ready
//  decoder_instqueue_rst_out       out  1             instruction queue clear pulse (JAL)
//  decoder_if_en_out               out  1             IF redirect pulse
//  decoder_if_addr_out             out  ADDR_WIDTH    redirect target
//  decoder_bp_en_out               out  1             branch-seen pulse
//  decoder_bp_pc_out               out  ADDR_WIDTH    branch PC
//  decoder_bp_target_out           out  ADDR_WIDTH    branch PC + B-immediate
//  decoder_dispatcher_en_out       out  1             FIFO head valid
//  dispatcher_decoder_rdy_in       in   1             dispatcher accepts head
//  decoder_dispatcher_rs_out       out  REG_WIDTH     FIFO head source register rs
//  decoder_dispatcher_rt_out       out  REG_WIDTH     FIFO head source register rt
//  decoder_dispatcher_rd_out       out  REG_WIDTH     FIFO head destination register rd
//  decoder_dispatcher_imm_out      out  INST_WIDTH    FIFO head immediate
//  decoder_dispatcher_opcode_out   out  OPCODE_WIDTH  FIFO head instruction type
//  decoder_dispatcher_pc_out       out  ADDR_WIDTH    FIFO head PC
//  decoder_dispatcher_illegal_out  out  1             FIFO head is an illegal encoding
//  decoder_count_out               out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO empty; count 0; every pulse and data output 0; opcode `NOP.
//  rdy_in low: no state changes; registered pulses hold until the first edge with rdy_in high.
//  Upstream ready: rdy_out = rdy_in & !full & !flush_in & !redirect_pending.
//    No combinational path from dispatcher_decoder_rdy_in to rdy_out.
//  Push: en_in & rdy_out at an edge. Decoded entry is visible at the head no earlier than the next cycle.
//    Push-to-en_out latency is 1 cycle when the FIFO is empty.
//  Pop: en_out & dispatcher_rdy_in & rdy_in. Push and pop in the same cycle is legal; count unchanged.
//  FIFO: wrap-around pointers with an extra bit; full = count == DEPTH.
//  Head outputs are driven from FIFO storage. They hold their value while en_out is 0.
//  Decode:
//    Fields not used by a format are 0 (no latches).
//    I/S/B/J immediates are sign-extended; U immediate is {inst[31:12], 12'b0}.
//    Shift immediate is zero-extended inst[24:20].
//  Illegal: any of the following enqueues opcode `NOP with illegal = 1:
//    unknown major opcode;
//    unused funct3 (loads 3/6/7, stores >= 3, branches 2/3);
//    R-type funct7 not 0, or not 0x20 where SUB/SRA apply;
//    SLLI funct7 != 0; SRLI/SRAI funct7 not 0 or 0x20.
//  JAL push:
//    Next cycle, pulse if_en = 1 and instqueue_rst = 1 for one cycle, with if_addr = pc + J-immediate.
//    redirect_pending is high during that cycle, so the wrong-path word presented then is not accepted.
//  Branch push:
//    Next cycle, pulse bp_en = 1 for one cycle, with bp_pc = pc and bp_target = pc + B-immediate (mod 2^ADDR_WIDTH).
//  flush_in (edge with rdy_in high): FIFO emptied; count 0; pending redirect and bp pulses cancelled.
//    Flush beats a simultaneous push or pop.
//  Reset asserted mid-operation: immediate asynchronous return to reset values.
// STRUCTURE
//  constant.vh: instruction-type codes (`NOP, `ADD .. `LUI), RV major opcodes, `InstTypeWidth.
//  Sub-module rv32i_decode_comb: purely combinational.
//    inst/pc -> rs, rt, rd, imm, opcode, illegal, is_jal, is_branch, jal_target, br_target.
//  The top level owns the FIFO, the handshakes, and the pulse registers.
// TESTING
//  1. Reset, then push ADDI x1,x0,-5 (0xFFB00093) with dispatcher ready.
//     -> next cycle: en_out = 1, opcode `ADDI, rd 1, imm 0xFFFFFFFB.
//  2. Dispatcher ready held 0; push 5 instructions with DEPTH 4.
//     -> rdy_out drops after 4 pushes; count 4; 5th word not accepted; FIFO order preserved on drain.
//  3. JAL x1,+8 at pc 0x100.
//     -> next cycle: if_en = 1, instqueue_rst = 1, if_addr 0x108, rdy_out = 0; exactly one entry enqueued.
//  4. BEQ at pc 0x200 with imm -4.
//     -> next cycle: bp_en = 1, bp_pc 0x200, bp_target 0x1FC; entry opcode `BEQ.
//  5. FIFO holds 3 entries; assert flush_in together with a push and a pop.
//     -> count 0, en_out = 0, pushed word dropped.
//  6. Push 0x0000707F (opcode 0x7F) and a load with funct3 = 3.
//     -> both dequeue as `NOP with illegal = 1; rdy_in low for 2 cycles freezes count and outputs.

Source files
------------

// File: rtl/decode_buffer_pkg.sv
// rtl/decode_buffer_pkg.sv - instruction-type codes and RV32I major opcodes for the decode stage
package decode_buffer_pkg;

    localparam int INST_TYPE_WIDTH = 6;

    // IT_NOP must stay at zero: cleared FIFO storage then reads back as a NOP.
    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        IT_NOP = 0,
        IT_LUI, IT_AUIPC, IT_JAL, IT_JALR,
        IT_BEQ, IT_BNE, IT_BLT, IT_BGE, IT_BLTU, IT_BGEU,
        IT_LB, IT_LH, IT_LW, IT_LBU, IT_LHU,
        IT_SB, IT_SH, IT_SW,
        IT_ADDI, IT_SLTI, IT_SLTIU, IT_XORI, IT_ORI, IT_ANDI,
        IT_SLLI, IT_SRLI, IT_SRAI,
        IT_ADD, IT_SUB, IT_SLL, IT_SLT, IT_SLTU, IT_XOR,
        IT_SRL, IT_SRA, IT_OR, IT_AND
    } inst_type_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/decode_buffer_decode.sv
// rtl/decode_buffer_decode.sv - purely combinational RV32I field and immediate decoder
module rv32i_decode_comb
    import decode_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int INST_WIDTH   = 32,
    parameter int REG_WIDTH    = 5,
    parameter int OPCODE_WIDTH = 6
) (
    input  logic [INST_WIDTH-1:0]   inst,
    input  logic [ADDR_WIDTH-1:0]   pc,
    output logic [REG_WIDTH-1:0]    rs,
    output logic [REG_WIDTH-1:0]    rt,
    output logic [REG_WIDTH-1:0]    rd,
    output logic [INST_WIDTH-1:0]   imm,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    illegal,
    output logic                    is_jal,
    output logic                    is_branch,
    output logic [ADDR_WIDTH-1:0]   jal_target,
    output logic [ADDR_WIDTH-1:0]   br_target
);

    logic [6:0]            maj;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic [INST_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    inst_type_e            itype;

    // Field extraction, immediate formats and branch/jump targets
    always_comb begin
        maj    = inst[6:0];
        f3     = inst[14:12];
        f7     = inst[31:25];
        imm_i  = {{(INST_WIDTH-12){inst[31]}}, inst[31:20]};
        imm_s  = {{(INST_WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
        imm_b  = {{(INST_WIDTH-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u  = {inst[31:12], 12'b0};
        imm_j  = {{(INST_WIDTH-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_sh = {{(INST_WIDTH-5){1'b0}}, inst[24:20]};
        jal_target = pc + ADDR_WIDTH'(imm_j);
        br_target  = pc + ADDR_WIDTH'(imm_b);
    end

    // Per-format decode; fields unused by a format stay 0, illegal encodings collapse to NOP
    always_comb begin
        itype     = IT_NOP;
        rs        = '0;
        rt        = '0;
        rd        = '0;
        imm       = '0;
        illegal   = 1'b0;
        is_jal    = 1'b0;
        is_branch = 1'b0;
        case (maj)
            OPC_LUI: begin
                itype = IT_LUI;   rd = inst[11:7]; imm = imm_u;
            end
            OPC_AUIPC: begin
                itype = IT_AUIPC; rd = inst[11:7]; imm = imm_u;
            end
            OPC_JAL: begin
                itype = IT_JAL;   rd = inst[11:7]; imm = imm_j; is_jal = 1'b1;
            end
            OPC_JALR: begin
                itype = IT_JALR;  rs = inst[19:15]; rd = inst[11:7]; imm = imm_i;
            end
            OPC_BRANCH: begin
                rs = inst[19:15]; rt = inst[24:20]; imm = imm_b; is_branch = 1'b1;
                case (f3)
                    3'd0:    itype = IT_BEQ;
                    3'd1:    itype = IT_BNE;
                    3'd4:    itype = IT_BLT;
                    3'd5:    itype = IT_BGE;
                    3'd6:    itype = IT_BLTU;
                    3'd7:    itype = IT_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                rs = inst[19:15]; rd = inst[11:7]; imm = imm_i;
                case (f3)
                    3'd0:    itype = IT_LB;
                    3'd1:    itype = IT_LH;
                    3'd2:    itype = IT_LW;
                    3'd4:    itype = IT_LBU;
                    3'd5:    itype = IT_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                rs = inst[19:15]; rt = inst[24:20]; imm = imm_s;
                case (f3)
                    3'd0:    itype = IT_SB;
                    3'd1:    itype = IT_SH;
                    3'd2:    itype = IT_SW;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_IMM: begin
                rs = inst[19:15]; rd = inst[11:7]; imm = imm_i;
                case (f3)
                    3'd0: itype = IT_ADDI;
                    3'd2: itype = IT_SLTI;
                    3'd3: itype = IT_SLTIU;
                    3'd4: itype = IT_XORI;
                    3'd6: itype = IT_ORI;
                    3'd7: itype = IT_ANDI;
                    3'd1: begin
                        imm   = imm_sh;
                        itype = IT_SLLI;
                        illegal = (f7 != F7_ZERO);
                    end
                    default: begin
                        imm = imm_sh;
                        if (f7 == F7_ZERO)     itype = IT_SRLI;
                        else if (f7 == F7_ALT) itype = IT_SRAI;
                        else                   illegal = 1'b1;
                    end
                endcase
            end
            OPC_REG: begin
                rs = inst[19:15]; rt = inst[24:20]; rd = inst[11:7];
                case (f3)
                    3'd0: begin
                        if (f7 == F7_ZERO)     itype = IT_ADD;
                        else if (f7 == F7_ALT) itype = IT_SUB;
                        else                   illegal = 1'b1;
                    end
                    3'd5: begin
                        if (f7 == F7_ZERO)     itype = IT_SRL;
                        else if (f7 == F7_ALT) itype = IT_SRA;
                        else                   illegal = 1'b1;
                    end
                    default: begin
                        illegal = (f7 != F7_ZERO);
                        case (f3)
                            3'd1:    itype = IT_SLL;
                            3'd2:    itype = IT_SLT;
                            3'd3:    itype = IT_SLTU;
                            3'd4:    itype = IT_XOR;
                            3'd6:    itype = IT_OR;
                            default: itype = IT_AND;
                        endcase
                    end
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            itype     = IT_NOP;
            rs        = '0;
            rt        = '0;
            rd        = '0;
            imm       = '0;
            is_jal    = 1'b0;
            is_branch = 1'b0;
        end
        opcode = OPCODE_WIDTH'(itype);
    end

endmodule

// File: rtl/decode_buffer.sv
// rtl/decode_buffer.sv - buffered RV32I decode stage with JAL redirect and branch hint pulses
module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int INST_WIDTH   = 32,
    parameter int REG_WIDTH    = 5,
    parameter int OPCODE_WIDTH = 6,
    parameter int DEPTH        = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      instqueue_decoder_en_in,
    input  logic [INST_WIDTH-1:0]     instqueue_decoder_inst_in,
    input  logic [ADDR_WIDTH-1:0]     instqueue_decoder_pc_in,
    output logic                      decoder_instqueue_rdy_out,
    output logic                      decoder_instqueue_rst_out,
    output logic                      decoder_if_en_out,
    output logic [ADDR_WIDTH-1:0]     decoder_if_addr_out,
    output logic                      decoder_bp_en_out,
    output logic [ADDR_WIDTH-1:0]     decoder_bp_pc_out,
    output logic [ADDR_WIDTH-1:0]     decoder_bp_target_out,
    output logic                      decoder_dispatcher_en_out,
    input  logic                      dispatcher_decoder_rdy_in,
    output logic [REG_WIDTH-1:0]      decoder_dispatcher_rs_out,
    output logic [REG_WIDTH-1:0]      decoder_dispatcher_rt_out,
    output logic [REG_WIDTH-1:0]      decoder_dispatcher_rd_out,
    output logic [INST_WIDTH-1:0]     decoder_dispatcher_imm_out,
    output logic [OPCODE_WIDTH-1:0]   decoder_dispatcher_opcode_out,
    output logic [ADDR_WIDTH-1:0]     decoder_dispatcher_pc_out,
    output logic                      decoder_dispatcher_illegal_out,
    output logic [$clog2(DEPTH):0]    decoder_count_out
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [REG_WIDTH-1:0]    rs;
        logic [REG_WIDTH-1:0]    rt;
        logic [REG_WIDTH-1:0]    rd;
        logic [INST_WIDTH-1:0]   imm;
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [ADDR_WIDTH-1:0]   pc;
        logic                    illegal;
    } entry_t;

    entry_t                mem [DEPTH];
    entry_t                dec_entry;
    entry_t                head;
    logic [PTR_W:0]        wr_ptr, rd_ptr, count;
    logic                  full, empty, push, pop;
    logic                  dec_is_jal, dec_is_branch;
    logic [ADDR_WIDTH-1:0] dec_jal_target, dec_br_target;

    rv32i_decode_comb #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .INST_WIDTH   (INST_WIDTH),
        .REG_WIDTH    (REG_WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_decode (
        .inst       (instqueue_decoder_inst_in),
        .pc         (instqueue_decoder_pc_in),
        .rs         (dec_entry.rs),
        .rt         (dec_entry.rt),
        .rd         (dec_entry.rd),
        .imm        (dec_entry.imm),
        .opcode     (dec_entry.opcode),
        .illegal    (dec_entry.illegal),
        .is_jal     (dec_is_jal),
        .is_branch  (dec_is_branch),
        .jal_target (dec_jal_target),
        .br_target  (dec_br_target)
    );

    assign dec_entry.pc = instqueue_decoder_pc_in;

    // Handshake decisions; upstream ready never depends on the dispatcher's ready
    always_comb begin
        count = wr_ptr - rd_ptr;
        full  = (count == (PTR_W+1)'(DEPTH));
        empty = (count == '0);
        decoder_instqueue_rdy_out = rdy_in & ~full & ~flush_in & ~decoder_if_en_out;
        push  = instqueue_decoder_en_in & decoder_instqueue_rdy_out;
        pop   = ~empty & dispatcher_decoder_rdy_in & rdy_in;
        head  = mem[rd_ptr[PTR_W-1:0]];
    end

    // Wrap-around pointers; a flush snaps the write pointer back so the head slot is left untouched
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                wr_ptr <= rd_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage; cleared storage decodes as a NOP with all fields zero
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= dec_entry;
        end
    end

    // One-cycle redirect and branch-hint pulses; they freeze with rdy_in low and die on a flush
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            decoder_if_en_out         <= 1'b0;
            decoder_instqueue_rst_out <= 1'b0;
            decoder_if_addr_out       <= '0;
            decoder_bp_en_out         <= 1'b0;
            decoder_bp_pc_out         <= '0;
            decoder_bp_target_out     <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                decoder_if_en_out         <= 1'b0;
                decoder_instqueue_rst_out <= 1'b0;
                decoder_bp_en_out         <= 1'b0;
            end else begin
                decoder_if_en_out         <= push & dec_is_jal;
                decoder_instqueue_rst_out <= push & dec_is_jal;
                decoder_bp_en_out         <= push & dec_is_branch;
                if (push && dec_is_jal) decoder_if_addr_out <= dec_jal_target;
                if (push && dec_is_branch) begin
                    decoder_bp_pc_out     <= instqueue_decoder_pc_in;
                    decoder_bp_target_out <= dec_br_target;
                end
            end
        end
    end

    assign decoder_dispatcher_en_out      = ~empty;
    assign decoder_dispatcher_rs_out      = head.rs;
    assign decoder_dispatcher_rt_out      = head.rt;
    assign decoder_dispatcher_rd_out      = head.rd;
    assign decoder_dispatcher_imm_out     = head.imm;
    assign decoder_dispatcher_opcode_out  = head.opcode;
    assign decoder_dispatcher_pc_out      = head.pc;
    assign decoder_dispatcher_illegal_out = head.illegal;
    assign decoder_count_out              = count;

endmodule
